// File: rtl/fx3_bus_out_control_if.sv
// Response/FX3 write-bus bundle for fx3_bus_out_control.
// The master side drives responses, ppfifo writes and FX3 flow control; the slave side serialises.
interface fx3_bus_out_control_if;
  logic        i_response_stb;
  logic [7:0]  i_status;
  logic [7:0]  i_flag;
  logic [31:0] i_rw_count;
  logic [31:0] i_address;
  logic        i_data_phase;
  logic        o_busy;
  logic        o_response_done;
  logic [1:0]  o_out_ready;
  logic [1:0]  i_out_activate;
  logic [23:0] o_out_fifo_size;
  logic        i_out_strobe;
  logic [31:0] i_out_data;
  logic        o_write_fx3_packet;
  logic        i_fx3_ready;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic        o_packet_end;
  logic        i_write_fx3_finished;

  modport master (
    output i_response_stb, i_status, i_flag, i_rw_count, i_address, i_data_phase,
    output i_out_activate, i_out_strobe, i_out_data, i_fx3_ready, i_write_fx3_finished,
    input  o_busy, o_response_done, o_out_ready, o_out_fifo_size,
    input  o_write_fx3_packet, o_data, o_data_valid, o_packet_end
  );

  modport slave (
    input  i_response_stb, i_status, i_flag, i_rw_count, i_address, i_data_phase,
    input  i_out_activate, i_out_strobe, i_out_data, i_fx3_ready, i_write_fx3_finished,
    output o_busy, o_response_done, o_out_ready, o_out_fifo_size,
    output o_write_fx3_packet, o_data, o_data_valid, o_packet_end
  );
endinterface

// File: rtl/fx3_bus_out_control.sv
// Serialises a 4-word response header plus optional ppfifo read data onto the FX3 write bus,
// splitting the stream into DMA packets of MAX_PACKET_WORDS words.
module fx3_bus_out_control #(
  parameter int          ADDRESS_WIDTH    = 8,
  parameter logic [15:0] ID_WORD          = 16'hC0DE,
  parameter int          MAX_PACKET_WORDS = 256
) (
  input logic                  clk,
  input logic                  rst,
  fx3_bus_out_control_if.slave bus
);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam int CW    = ADDRESS_WIDTH + 1;
  localparam int PW    = $clog2(MAX_PACKET_WORDS) + 1;
  localparam logic [PW-1:0] PKT_LAST = PW'(MAX_PACKET_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, SEND_STATUS, SEND_COUNT, SEND_ADDRESS, SEND_CHECKSUM, SEND_DATA, FINISHED
  } state_t;
  typedef enum logic [1:0] {B_EMPTY, B_WRITING, B_FULL, B_READING} buf_t;

  function automatic logic [31:0] checksum(input logic [31:0] a, b, c);
    return a + b + c;
  endfunction

  state_t        state, next;
  logic [7:0]    status_q, flag_q;
  logic [31:0]   count_q, address_q;
  logic          phase_q;
  logic          has_data;
  logic [31:0]   w0;
  logic [31:0]   fetch_cnt, data_cnt;
  logic [PW-1:0] pkt_cnt;
  logic          done_q;
  buf_t          bstate [2];
  logic [CW-1:0] bcount [2];
  logic [31:0]   mem [2][DEPTH];
  logic          rd_active, rd_sel;
  logic [CW-1:0] rd_ptr;
  logic [31:0]   data_p1;
  logic          vld_p1;
  logic          valid, xfer, take, fetch, wsel, wen, last_word, capture;

  assign capture  = (state == IDLE) && bus.i_response_stb;
  assign has_data = phase_q && (count_q != 32'd0);
  assign w0       = {ID_WORD, flag_q, status_q};
  assign xfer     = valid && bus.i_fx3_ready;
  assign take     = xfer && (state == SEND_DATA);
  assign wsel     = (bstate[0] == B_WRITING) ? 1'b0 : 1'b1;
  assign wen      = bus.i_out_strobe && (bstate[wsel] == B_WRITING) &&
                    bus.i_out_activate[wsel] && (bcount[wsel] < CW'(DEPTH));
  // Prefetch starts under the checksum word so data follows the header without a bubble.
  assign fetch    = rd_active && (fetch_cnt < count_q) && (rd_ptr < bcount[rd_sel]) &&
                    (((state == SEND_CHECKSUM) && has_data) || (state == SEND_DATA)) &&
                    (!vld_p1 || take);

  always_ff @(posedge clk) begin
    if (capture) begin
      status_q  <= bus.i_status;
      flag_q    <= bus.i_flag;
      count_q   <= bus.i_rw_count;
      address_q <= bus.i_address;
      phase_q   <= bus.i_data_phase;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:          if (bus.i_response_stb) next = SEND_STATUS;
      SEND_STATUS:   if (xfer) next = SEND_COUNT;
      SEND_COUNT:    if (xfer) next = SEND_ADDRESS;
      SEND_ADDRESS:  if (xfer) next = SEND_CHECKSUM;
      SEND_CHECKSUM: if (xfer) next = has_data ? SEND_DATA : FINISHED;
      SEND_DATA:     if (xfer && (data_cnt == count_q - 32'd1)) next = FINISHED;
      FINISHED:      if (bus.i_write_fx3_finished) next = IDLE;
      default:       next = IDLE;
    endcase
  end

  always_comb begin
    valid     = 1'b0;
    bus.o_data = 32'd0;
    case (state)
      SEND_STATUS:   begin valid = 1'b1; bus.o_data = w0;        end
      SEND_COUNT:    begin valid = 1'b1; bus.o_data = count_q;   end
      SEND_ADDRESS:  begin valid = 1'b1; bus.o_data = address_q; end
      SEND_CHECKSUM: begin valid = 1'b1; bus.o_data = checksum(w0, count_q, address_q); end
      SEND_DATA:     begin valid = vld_p1; bus.o_data = data_p1; end
      default:       ;
    endcase
    last_word = ((state == SEND_CHECKSUM) && !has_data) ||
                ((state == SEND_DATA) && (data_cnt == count_q - 32'd1));
    bus.o_data_valid       = valid;
    bus.o_packet_end       = valid && ((pkt_cnt == PKT_LAST) || last_word);
    bus.o_write_fx3_packet = (state != IDLE);
    bus.o_busy             = (state != IDLE);
    bus.o_response_done    = done_q;
    bus.o_out_ready        = {bstate[1] == B_EMPTY, bstate[0] == B_EMPTY};
    bus.o_out_fifo_size    = 24'(DEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      data_cnt  <= '0;
      pkt_cnt   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state == FINISHED) && bus.i_write_fx3_finished;
      if (capture) begin
        fetch_cnt <= '0;
        data_cnt  <= '0;
        pkt_cnt   <= '0;
      end else begin
        if (xfer) pkt_cnt <= (pkt_cnt == PKT_LAST) ? '0 : pkt_cnt + PW'(1);
        if (take) data_cnt <= data_cnt + 32'd1;
        if (fetch) fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wen) mem[wsel][bcount[wsel][ADDRESS_WIDTH-1:0]] <= bus.i_out_data;
  end

  // ppfifo read -> staging register (p1): holds one word until the FX3 accepts it
  always_ff @(posedge clk) begin
    if (fetch) data_p1 <= mem[rd_sel][rd_ptr[ADDRESS_WIDTH-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst)        vld_p1 <= 1'b0;
    else if (fetch) vld_p1 <= 1'b1;
    else if (take)  vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bstate[0] <= B_EMPTY;
      bstate[1] <= B_EMPTY;
      bcount[0] <= '0;
      bcount[1] <= '0;
      rd_active <= 1'b0;
      rd_sel    <= 1'b0;
      rd_ptr    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (bstate[i])
          B_EMPTY:
            if (bus.i_out_activate[i]) begin
              bstate[i] <= B_WRITING;
              bcount[i] <= '0;
            end
          B_WRITING:
            if (!bus.i_out_activate[i]) bstate[i] <= (bcount[i] != '0) ? B_FULL : B_EMPTY;
            else if (wen && (wsel == 1'(i))) bcount[i] <= bcount[i] + CW'(1);
          default: ;
        endcase
      end
      if (!rd_active) begin
        if (bstate[0] == B_FULL) begin
          bstate[0] <= B_READING;
          rd_sel    <= 1'b0;
          rd_active <= 1'b1;
          rd_ptr    <= '0;
        end else if (bstate[1] == B_FULL) begin
          bstate[1] <= B_READING;
          rd_sel    <= 1'b1;
          rd_active <= 1'b1;
          rd_ptr    <= '0;
        end
      end else if (fetch) begin
        rd_ptr <= rd_ptr + CW'(1);
        // Hand the buffer back once drained or once the response needs no more words.
        if ((rd_ptr + CW'(1) == bcount[rd_sel]) || (fetch_cnt + 32'd1 == count_q)) begin
          bstate[rd_sel] <= B_EMPTY;
          rd_active      <= 1'b0;
        end
      end
    end
  end
endmodule
